// File: rtl/dhdu_pkg.sv
// Shared constants for the hazard/forwarding unit and its long-op scoreboard.
// Forwarding select codes and the hardwired-zero register number.
package dhdu_pkg;

  localparam int SEL_RF   = 0;
  localparam int REG_ZERO = 0;

  // The completion-bus select code sits just past the last pipeline stage.
  function automatic int sel_lu(input int num_stg);
    return num_stg + 1;
  endfunction

endpackage

// File: rtl/dhdu_sb.sv
// Long-op scoreboard: one pending bit per register, with a running popcount.
// Lookups are combinational from the registered bits.
module dhdu_sb
  import dhdu_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int AW      = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [AW-1:0]         set_rd,
  input  logic                  clr_en,
  input  logic [AW-1:0]         clr_rd,
  input  logic [NUM_SRC*AW-1:0] look_addr,
  output logic [NUM_SRC-1:0]    look_hit,
  input  logic [AW-1:0]         id_rd,
  output logic                  id_hit,
  output logic [AW:0]           pend_cnt
);

  localparam int NREG = 1 << AW;

  logic [NREG-1:0] sb_q, sb_d;
  logic            set_ok, inc, dec;

  assign set_ok = set_en && (set_rd != AW'(REG_ZERO));

  // A same-register set overrides the clear, so that case is not a decrement.
  assign inc = set_ok && !sb_q[set_rd];
  assign dec = clr_en && sb_q[clr_rd] && !(set_ok && (set_rd == clr_rd));

  always_comb begin
    sb_d = sb_q;
    if (clr_en) sb_d[clr_rd] = 1'b0;
    if (set_ok) sb_d[set_rd] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sb_q     <= '0;
      pend_cnt <= '0;
    end else begin
      sb_q     <= sb_d;
      pend_cnt <= pend_cnt + (AW+1)'(inc) - (AW+1)'(dec);
    end
  end

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_look
    assign look_hit[i] = sb_q[look_addr[i*AW +: AW]];
  end

  assign id_hit = sb_q[id_rd];

endmodule

// File: rtl/dhdu_scoreboard.sv
// ID-stage hazard detection and operand forwarding with a long-op scoreboard.
// Stall/forward decisions are combinational; pend_cnt and stall_cnt are registered.
module dhdu_scoreboard
  import dhdu_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int AW      = 5,
  parameter int NUM_STG = 3,
  parameter int SW      = $clog2(NUM_STG + 2),
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC*AW-1:0] src_addr,
  input  logic [NUM_SRC-1:0]    src_vld,
  input  logic [AW-1:0]         id_rd,
  input  logic                  id_we,
  input  logic [NUM_STG*AW-1:0] stg_rd,
  input  logic [NUM_STG-1:0]    stg_we,
  input  logic [NUM_STG-1:0]    stg_rdy,
  input  logic                  lu_issue,
  input  logic [AW-1:0]         lu_rd,
  input  logic                  lu_done,
  input  logic [AW-1:0]         lu_done_rd,
  input  logic                  flush,
  output logic                  nop,
  output logic                  le,
  output logic [NUM_SRC*SW-1:0] fwd_sel,
  output logic [AW:0]           pend_cnt,
  output logic [CNT_W-1:0]      stall_cnt
);

  logic [NUM_SRC-1:0]    sb_hit;
  logic                  id_hit;
  logic [NUM_SRC-1:0]    op_stall;
  logic [NUM_SRC*SW-1:0] sel_calc;
  logic                  waw, stall;

  dhdu_sb #(.NUM_SRC(NUM_SRC), .AW(AW)) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_en    (lu_issue),
    .set_rd    (lu_rd),
    .clr_en    (lu_done),
    .clr_rd    (lu_done_rd),
    .look_addr (src_addr),
    .look_hit  (sb_hit),
    .id_rd     (id_rd),
    .id_hit    (id_hit),
    .pend_cnt  (pend_cnt)
  );

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_op
    logic [AW-1:0] addr;
    logic          active, found, stl;
    logic [SW-1:0] sel;

    assign addr = src_addr[i*AW +: AW];

    // The youngest matching writer decides; an unready one blocks older stages.
    always_comb begin
      sel    = SW'(SEL_RF);
      stl    = 1'b0;
      found  = 1'b0;
      active = src_vld[i] && (addr != AW'(REG_ZERO));
      if (active) begin
        for (int k = 0; k < NUM_STG; k++) begin
          if (!found && stg_we[k] && (stg_rd[k*AW +: AW] != AW'(REG_ZERO)) &&
              (stg_rd[k*AW +: AW] == addr)) begin
            found = 1'b1;
            if (stg_rdy[k]) sel = SW'(k + 1);
            else            stl = 1'b1;
          end
        end
        if (!found && sb_hit[i]) begin
          if (lu_done && (lu_done_rd == addr)) sel = SW'(sel_lu(NUM_STG));
          else                                 stl = 1'b1;
        end
      end
    end

    assign op_stall[i]          = stl;
    assign sel_calc[i*SW +: SW] = sel;
  end

  assign waw   = id_we && (id_rd != AW'(REG_ZERO)) && id_hit &&
                 !(lu_done && (lu_done_rd == id_rd));
  assign stall = ((|op_stall) || waw) && !flush;

  always_comb begin
    nop     = 1'b0;
    le      = 1'b1;
    fwd_sel = '0;
    if (!reset) begin
      nop = stall;
      le  = !stall;
      if (!stall) fwd_sel = sel_calc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  stall_cnt <= '0;
    else if (nop && (stall_cnt != {CNT_W{1'b1}})) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_dhdu_scoreboard.sv
// Directed bench for dhdu_scoreboard with default parameters (3 operands, 3 stages).
// Inputs change on the falling edge; outputs are sampled 1 ns later or 1 ns after a rising edge.
module tb_dhdu_scoreboard;

  localparam int NUM_SRC = 3;
  localparam int AW      = 5;
  localparam int NUM_STG = 3;
  localparam int SW      = 3;
  localparam int CNT_W   = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_SRC*AW-1:0] src_addr;
  logic [NUM_SRC-1:0]    src_vld;
  logic [AW-1:0]         id_rd;
  logic                  id_we;
  logic [NUM_STG*AW-1:0] stg_rd;
  logic [NUM_STG-1:0]    stg_we;
  logic [NUM_STG-1:0]    stg_rdy;
  logic                  lu_issue;
  logic [AW-1:0]         lu_rd;
  logic                  lu_done;
  logic [AW-1:0]         lu_done_rd;
  logic                  flush;
  logic                  nop;
  logic                  le;
  logic [NUM_SRC*SW-1:0] fwd_sel;
  logic [AW:0]           pend_cnt;
  logic [CNT_W-1:0]      stall_cnt;

  int checks = 0;
  int passed = 0;

  dhdu_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .src_addr   (src_addr),
    .src_vld    (src_vld),
    .id_rd      (id_rd),
    .id_we      (id_we),
    .stg_rd     (stg_rd),
    .stg_we     (stg_we),
    .stg_rdy    (stg_rdy),
    .lu_issue   (lu_issue),
    .lu_rd      (lu_rd),
    .lu_done    (lu_done),
    .lu_done_rd (lu_done_rd),
    .flush      (flush),
    .nop        (nop),
    .le         (le),
    .fwd_sel    (fwd_sel),
    .pend_cnt   (pend_cnt),
    .stall_cnt  (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    src_addr = '0; src_vld = '0; id_rd = '0; id_we = 1'b0;
    stg_rd = '0; stg_we = '0; stg_rdy = '0;
    lu_issue = 1'b0; lu_rd = '0; lu_done = 1'b0; lu_done_rd = '0; flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    // Load-use on r5 would stall, but reset must force the safe outputs.
    src_addr[4:0] = 5'd5; src_vld = 3'b001;
    stg_rd[4:0] = 5'd5; stg_we = 3'b001;
    #2;
    checks++; if (nop !== 1'b0) $display("FAIL reset_nop got=%b exp=0", nop); else passed++;
    checks++; if (le !== 1'b1) $display("FAIL reset_le got=%b exp=1", le); else passed++;
    checks++; if (fwd_sel !== 9'd0) $display("FAIL reset_sel got=%h exp=0", fwd_sel); else passed++;
    checks++; if (pend_cnt !== 6'd0) $display("FAIL reset_pend got=%0d exp=0", pend_cnt); else passed++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); else passed++;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_forward();
    @(negedge clk);
    idle_inputs();
    src_addr[4:0] = 5'd5; src_vld = 3'b001;
    stg_rd[4:0] = 5'd5; stg_rd[9:5] = 5'd5; stg_we = 3'b011; stg_rdy = 3'b011;
    #1;
    checks++; if (fwd_sel[2:0] !== 3'd1) $display("FAIL fwd_ex_wins got=%0d exp=1", fwd_sel[2:0]); else passed++;
    checks++; if (nop !== 1'b0 || le !== 1'b1) $display("FAIL fwd_no_stall got nop=%b le=%b exp nop=0 le=1", nop, le); else passed++;
    // EX not writing: MEM takes over; WB-only on another operand.
    stg_we = 3'b110; stg_rdy = 3'b110; stg_rd[14:10] = 5'd6;
    src_addr[9:5] = 5'd6; src_vld = 3'b011;
    #1;
    checks++; if (fwd_sel !== 9'b000_011_010) $display("FAIL fwd_mem_wb got=%b exp=000011010", fwd_sel); else passed++;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    idle_inputs();
    src_addr[9:5] = 5'd7; src_vld = 3'b010;
    stg_rd[4:0] = 5'd7; stg_rd[9:5] = 5'd7; stg_we = 3'b011; stg_rdy = 3'b010;
    #1;
    checks++; if (nop !== 1'b1 || le !== 1'b0) $display("FAIL load_use_stall got nop=%b le=%b exp nop=1 le=0", nop, le); else passed++;
    checks++; if (fwd_sel !== 9'd0) $display("FAIL load_use_sel got=%h exp=0", fwd_sel); else passed++;
    checks++; if (stall_cnt !== 16'd0) $display("FAIL load_use_cnt_pre got=%0d exp=0", stall_cnt); else passed++;
    @(posedge clk); #1;
    checks++; if (stall_cnt !== 16'd1) $display("FAIL load_use_cnt_post got=%0d exp=1", stall_cnt); else passed++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_r0();
    @(negedge clk);
    idle_inputs();
    src_addr[4:0] = 5'd0; src_vld = 3'b001;
    stg_rd[4:0] = 5'd0; stg_we = 3'b001; stg_rdy = 3'b000;
    #1;
    checks++; if (nop !== 1'b0 || fwd_sel[2:0] !== 3'd0) $display("FAIL r0_no_stall got nop=%b sel0=%0d exp nop=0 sel0=0", nop, fwd_sel[2:0]); else passed++;
    // Unread operand matching an unready stage must not stall.
    src_addr[4:0] = 5'd7; src_vld = 3'b000; stg_rd[4:0] = 5'd7;
    #1;
    checks++; if (nop !== 1'b0 || fwd_sel !== 9'd0) $display("FAIL inactive_op got nop=%b sel=%h exp nop=0 sel=0", nop, fwd_sel); else passed++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_long_op();
    @(negedge clk);
    idle_inputs();
    lu_issue = 1'b1; lu_rd = 5'd9;
    @(negedge clk);
    lu_issue = 1'b0;
    checks++; if (pend_cnt !== 6'd1) $display("FAIL lu_pend_set got=%0d exp=1", pend_cnt); else passed++;
    src_addr[14:10] = 5'd9; src_vld = 3'b100;
    #1;
    checks++; if (nop !== 1'b1 || le !== 1'b0) $display("FAIL lu_raw got nop=%b le=%b exp nop=1 le=0", nop, le); else passed++;
    lu_done = 1'b1; lu_done_rd = 5'd9;
    #1;
    checks++; if (nop !== 1'b0 || fwd_sel[8:6] !== 3'd4) $display("FAIL lu_bypass got nop=%b sel2=%0d exp nop=0 sel2=4", nop, fwd_sel[8:6]); else passed++;
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd0) $display("FAIL lu_pend_clr got=%0d exp=0", pend_cnt); else passed++;
    checks++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt_hold got=%0d exp=1", stall_cnt); else passed++;
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_waw_flush();
    @(negedge clk);
    idle_inputs();
    lu_issue = 1'b1; lu_rd = 5'd12;
    @(negedge clk);
    lu_issue = 1'b0;
    id_we = 1'b1; id_rd = 5'd12;
    #1;
    checks++; if (nop !== 1'b1 || le !== 1'b0) $display("FAIL waw_stall got nop=%b le=%b exp nop=1 le=0", nop, le); else passed++;
    flush = 1'b1;
    #1;
    checks++; if (nop !== 1'b0 || le !== 1'b1) $display("FAIL waw_flush got nop=%b le=%b exp nop=0 le=1", nop, le); else passed++;
    @(posedge clk); #1;
    checks++; if (pend_cnt !== 6'd1 || stall_cnt !== 16'd1) $display("FAIL flush_state got pend=%0d cnt=%0d exp pend=1 cnt=1", pend_cnt, stall_cnt); else passed++;
    @(negedge clk);
    flush = 1'b0;
    lu_done = 1'b1; lu_done_rd = 5'd12;
    #1;
    checks++; if (nop !== 1'b0) $display("FAIL waw_bypass got nop=%b exp=0", nop); else passed++;
    // Set and clear of r12 together: set wins.
    id_we = 1'b0; lu_issue = 1'b1; lu_rd = 5'd12;
    @(negedge clk);
    lu_issue = 1'b0;
    checks++; if (pend_cnt !== 6'd1) $display("FAIL set_wins got=%0d exp=1", pend_cnt); else passed++;
    @(negedge clk);
    lu_done = 1'b0;
    checks++; if (pend_cnt !== 6'd0) $display("FAIL lu_clear got=%0d exp=0", pend_cnt); else passed++;
    // Repeat clear and a set of r0 are both no-ops.
    lu_done = 1'b1; lu_done_rd = 5'd12; lu_issue = 1'b1; lu_rd = 5'd0;
    @(negedge clk);
    idle_inputs();
    checks++; if (pend_cnt !== 6'd0) $display("FAIL noop_update got=%0d exp=0", pend_cnt); else passed++;
  endtask

  task automatic test_saturate_reset();
    @(negedge clk);
    idle_inputs();
    lu_issue = 1'b1; lu_rd = 5'd3;
    @(negedge clk);
    lu_issue = 1'b0;
    src_addr[4:0] = 5'd5; src_vld = 3'b001; stg_rd[4:0] = 5'd5; stg_we = 3'b001;
    repeat (70000) @(posedge clk);
    #1;
    checks++; if (stall_cnt !== 16'hFFFF) $display("FAIL stall_sat got=%0d exp=65535", stall_cnt); else passed++;
    checks++; if (pend_cnt !== 6'd1) $display("FAIL pend_pre_reset got=%0d exp=1", pend_cnt); else passed++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (stall_cnt !== 16'd0 || pend_cnt !== 6'd0) $display("FAIL midreset_regs got cnt=%0d pend=%0d exp 0 0", stall_cnt, pend_cnt); else passed++;
    checks++; if (le !== 1'b1 || nop !== 1'b0) $display("FAIL midreset_outs got le=%b nop=%b exp le=1 nop=0", le, nop); else passed++;
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    lu_done = 1'b1; lu_done_rd = 5'd3;
    @(negedge clk);
    idle_inputs();
    checks++; if (pend_cnt !== 6'd0) $display("FAIL stale_done got=%0d exp=0", pend_cnt); else passed++;
    src_addr[4:0] = 5'd3; src_vld = 3'b001;
    #1;
    checks++; if (nop !== 1'b0) $display("FAIL stale_raw got nop=%b exp=0", nop); else passed++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_r0();
    test_long_op();
    test_waw_flush();
    test_saturate_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dhdu_scoreboard.md
Name: dhdu_scoreboard

Overview:
- Parametrised successor to the hazard detection/forwarding unit; sits at the ID stage.
- Generalises operand count and forwarding depth.
- Treats GR0 as hardwired zero.
- Adds a registered scoreboard for a variable-latency long-op unit (multiply/divide), with RAW/WAW stalls, completion-bus bypass and a saturating stall counter.

Parameters:
- NUM_SRC, 3, source operands checked per ID instruction.
- AW, 5, register address width.
- NUM_STG, 3, forwarding stages; index 0 = youngest (EX), NUM_STG-1 = oldest (WB).
- SW, $clog2(NUM_STG+2), forwarding select width per operand.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- src_addr  in  NUM_SRC*AW  source register addresses; operand i at [i*AW +: AW].
- src_vld  in  NUM_SRC  operand i is actually read.
- id_rd  in  AW  ID instruction destination register.
- id_we  in  1  ID instruction writes id_rd.
- stg_rd  in  NUM_STG*AW  destination register per stage.
- stg_we  in  NUM_STG  stage writes its rd.
- stg_rdy  in  NUM_STG  stage result is available for forwarding (0 for a load in EX).
- lu_issue  in  1  long-op issued this cycle (from EX).
- lu_rd  in  AW  long-op destination register.
- lu_done  in  1  long-op result on completion bus this cycle.
- lu_done_rd  in  AW  completing register.
- flush  in  1  ID instruction is being killed.
- nop  out  1  insert bubble into EX.
- le  out  1  IF/ID load enable.
- fwd_sel  out  NUM_SRC*SW  per-operand select: 0 = register file, k+1 = stage k, NUM_STG+1 = long-op completion bus.
- pend_cnt  out  AW+1  number of scoreboard bits set.
- stall_cnt  out  CNT_W  cycles with nop=1, saturating.

Behaviour:
- Reset (async): scoreboard, pend_cnt and stall_cnt go to 0. While reset is high, force nop=0, le=1, fwd_sel=0.
- nop, le, fwd_sel are combinational from inputs plus registered scoreboard (zero latency). pend_cnt and stall_cnt are registered.
- An operand is active when src_vld[i]=1 and src_addr[i]!=0. Inactive operands get sel=0 and never stall. Stages with rd=0 never match.
- Per active operand, scan stages 0..NUM_STG-1. The first stage with stg_we=1 and rd match wins:
  - if stg_rdy=1: sel = k+1;
  - if stg_rdy=0: load-use stall. Older stages are never consulted for that operand.
- If no stage matches and the scoreboard bit for the address is set:
  - lu_done=1 with lu_done_rd equal to the address: sel = NUM_STG+1, no stall;
  - otherwise: RAW stall.
- WAW stall: id_we=1, id_rd!=0, scoreboard bit for id_rd set, and not (lu_done with lu_done_rd==id_rd).
- stall = any load-use, RAW or WAW condition, and flush=0.
  - stall=1: nop=1, le=0, all fwd_sel=0.
  - stall=0: nop=0, le=1, fwd_sel as computed.
- flush=1 suppresses stall (nop=0, le=1) and does not affect the scoreboard.
- Scoreboard update on clk:
  - clear bit[lu_done_rd] if lu_done;
  - set bit[lu_rd] if lu_issue and lu_rd!=0.
  - Same register in the same cycle: set wins.
  - Set of an already-set bit and clear of an already-clear bit are no-ops.
  - Bit 0 is never set.
- pend_cnt tracks the popcount: +1 on a 0->1 transition, -1 on a 1->0 transition, net per cycle.
- stall_cnt increments each cycle nop=1 and holds at 2^CNT_W-1.
- Reset mid-operation discards all pending entries. Completions arriving afterwards for those registers are no-ops.

Decomposition:
- Shared package dhdu_pkg: select-code constants SEL_RF=0, SEL_LU(NUM_STG) function, and the register-zero constant.
- Sub-module dhdu_sb: scoreboard bit array, set/clear logic and pend_cnt, with a combinational lookup port per operand plus id_rd.
- Top level holds the match/priority logic and stall_cnt.

Test Plan:
- Defaults, src0=r5 active, stg_rd={EX:r5, MEM:r5}, both we=1, rdy=1 -> sel0=1 (EX wins), nop=0, le=1.
- src1=r7, EX rd=r7 we=1 rdy=0, MEM rd=r7 rdy=1 -> nop=1, le=0, sel=0, stall_cnt 0->1 next edge.
- src0=r0, EX rd=r0 we=1 rdy=0 -> no stall, sel0=0.
- lu_issue r9; next cycle src2=r9 -> stall; with lu_done r9 that cycle -> sel2=4, no stall; next cycle pend_cnt=0.
- Scoreboard holds r12, id_we=1 id_rd=r12 -> WAW stall; same with flush=1 -> nop=0, le=1, pend_cnt stays 1.
- Hold a stall 70000 cycles (CNT_W=16) -> stall_cnt saturates at 65535. Assert reset mid-stall -> stall_cnt=0, pend_cnt=0, le=1 immediately.
